// File: rtl/nand_seq_driver.sv
// Sequencer for the bit-serial 4-bit NAND ALU: it issues one operation, waits for
// the serial result, checks it and returns it on a valid/ready response port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FLUSH   | opcode held at 000 for 4 edges so a busy ALU drains to idle
// IDLE    | req_ready=1, waiting for a request
// RUN     | opcode 011 driven while the ALU shifts out 4 result bits
// CAPTURE | sample alu_c, compare against ~(a & b), build status
// RESP    | response held until the consumer takes it
module nand_seq_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [2:0] req_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_c,
    output logic [1:0] rsp_status,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [3:0] alu_c
);

    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_ILLEGAL  = 2'b01;
    localparam logic [1:0] ST_MISMATCH = 2'b10;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_RUN,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] cnt;
    logic       accept;
    logic       is_nand;
    logic       ops_zero;
    logic [3:0] expected;

    assign accept   = req_valid & req_ready;
    assign is_nand  = (req_op == OP_NAND);
    assign ops_zero = (alu_a == 4'd0) && (alu_b == 4'd0);
    assign expected = ~(alu_a & alu_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FLUSH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FLUSH:   if (cnt == 2'd3) state_nx = S_IDLE;
            S_IDLE:    if (accept) state_nx = is_nand ? S_RUN : S_RESP;
            S_RUN:     if (cnt == 2'd3) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_RESP;
            S_RESP:    if (rsp_valid && rsp_ready) state_nx = S_IDLE;
            default:   state_nx = S_FLUSH;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
    end

    // Illegal-opcode responses reach RESP with rsp_valid still low; it rises one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            rsp_valid  <= 1'b0;
            rsp_c      <= 4'd0;
            rsp_status <= ST_OK;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_opcode <= OP_NOP;
        end else begin
            case (state)
                S_FLUSH: begin
                    cnt <= cnt + 2'd1;
                end
                S_IDLE: begin
                    if (accept) begin
                        if (is_nand) begin
                            alu_a      <= req_a;
                            alu_b      <= req_b;
                            alu_opcode <= OP_NAND;
                            cnt        <= 2'd0;
                        end else begin
                            rsp_c      <= 4'd0;
                            rsp_status <= ST_ILLEGAL;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) alu_opcode <= OP_NOP;
                end
                S_CAPTURE: begin
                    rsp_valid <= 1'b1;
                    // Zero operands make the ALU abort early with C[3:2] stale.
                    if (ops_zero) begin
                        rsp_c      <= 4'b1111;
                        rsp_status <= ST_OK;
                    end else begin
                        rsp_c      <= alu_c;
                        rsp_status <= (alu_c == expected) ? ST_OK : ST_MISMATCH;
                    end
                end
                S_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    alu_opcode <= OP_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_seq_driver.sv
// Directed bench for nand_seq_driver with a behavioural model of the serial NAND ALU.
module tb_nand_seq_driver;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [2:0] req_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_c;
    logic [1:0] rsp_status;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_c;

    int vectors;
    int miscompares;

    nand_seq_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_c      (rsp_c),
        .rsp_status (rsp_status),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial ALU model: starts when idle and opcode is 011, one bit per edge, LSB first.
    // With both operands zero it stops writing after C[1], leaving C[3:2] stale.
    logic       alu_busy;
    int         alu_idx;
    int         alu_starts;
    logic [3:0] alu_corrupt;

    initial begin
        alu_busy    = 1'b0;
        alu_idx     = 0;
        alu_starts  = 0;
        alu_c       = 4'd0;
        alu_corrupt = 4'd0;
    end

    always @(posedge clk) begin
        if (!alu_busy) begin
            if (alu_opcode == 3'b011) begin
                alu_busy   <= 1'b1;
                alu_idx    <= 1;
                alu_starts <= alu_starts + 1;
                alu_c[0]   <= ~(alu_a[0] & alu_b[0]) ^ alu_corrupt[0];
            end
        end else begin
            if (!((alu_a == 4'd0) && (alu_b == 4'd0) && alu_idx >= 2))
                alu_c[alu_idx] <= ~(alu_a[alu_idx] & alu_b[alu_idx]) ^ alu_corrupt[alu_idx];
            if (alu_idx == 3) alu_busy <= 1'b0;
            alu_idx <= alu_idx + 1;
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready_timeout: req_ready=%b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic check_flush(input string tag);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== (i == 4)) begin
                miscompares++;
                $display("FAIL %s req_ready edge %0d: got %b want %b", tag, i, req_ready, (i == 4));
            end
            vectors++;
            if (alu_opcode !== 3'b000) begin
                miscompares++;
                $display("FAIL %s alu_opcode edge %0d: got %b want 000", tag, i, alu_opcode);
            end
        end
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s handshake: rsp_valid=%b req_ready=%b want 0 1", tag, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_c !== 4'd0 || rsp_status !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_rsp: ready=%b valid=%b c=%b st=%b want 0 0 0000 00",
                     req_ready, rsp_valid, rsp_c, rsp_status);
        end
        vectors++;
        if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_opcode !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_alu: a=%b b=%b op=%b want 0000 0000 000", alu_a, alu_b, alu_opcode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_flush("reset_flush");
    endtask

    task automatic test_nand_basic;
        int starts0;
        starts0 = alu_starts;
        send(4'b1010, 4'b0110, 3'b011);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (alu_opcode !== 3'b011 || rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_run T+%0d: op=%b valid=%b want 011 0", i, alu_opcode, rsp_valid);
            end
            @(negedge clk);
        end
        vectors++;
        if (alu_opcode !== 3'b000 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_T+4: op=%b valid=%b want 000 0", alu_opcode, rsp_valid);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_c !== 4'b1101 || rsp_status !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_rsp: valid=%b c=%b st=%b want 1 1101 00", rsp_valid, rsp_c, rsp_status);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_next_accept_T+6: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        vectors++;
        if (alu_starts !== starts0 + 1) begin
            miscompares++;
            $display("FAIL basic_alu_starts: got %0d want %0d", alu_starts, starts0 + 1);
        end
    endtask

    task automatic test_illegal;
        send(4'b1111, 4'b0000, 3'b010);
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || alu_opcode !== 3'b000) begin
            miscompares++;
            $display("FAIL illegal_T: valid=%b ready=%b op=%b want 0 0 000", rsp_valid, req_ready, alu_opcode);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_c !== 4'd0 || rsp_status !== 2'b01) begin
            miscompares++;
            $display("FAIL illegal_rsp: valid=%b c=%b st=%b want 1 0000 01", rsp_valid, rsp_c, rsp_status);
        end
        vectors++;
        if (alu_a !== 4'b1010 || alu_b !== 4'b0110 || alu_opcode !== 3'b000) begin
            miscompares++;
            $display("FAIL illegal_alu_untouched: a=%b b=%b op=%b want 1010 0110 000", alu_a, alu_b, alu_opcode);
        end
        handshake("illegal");
    endtask

    task automatic test_back_to_back;
        send(4'hF, 4'hF, 3'b011);
        req_valid = 1'b1;
        req_a     = 4'h3;
        req_b     = 4'h5;
        req_op    = 3'b011;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_c !== 4'b0000 || rsp_status !== 2'b00 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_stall %0d: valid=%b c=%b st=%b ready=%b want 1 0000 00 0",
                         i, rsp_valid, rsp_c, rsp_status, req_ready);
            end
            vectors++;
            if (alu_opcode !== 3'b000 || alu_a !== 4'hF) begin
                miscompares++;
                $display("FAIL b2b_stall_alu %0d: op=%b a=%h want 000 f", i, alu_opcode, alu_a);
            end
            if (i < 3) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_handshake1: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (alu_opcode !== 3'b011 || alu_a !== 4'h3 || alu_b !== 4'h5) begin
            miscompares++;
            $display("FAIL b2b_second_accept: op=%b a=%h b=%h want 011 3 5", alu_opcode, alu_a, alu_b);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_c !== 4'b1110 || rsp_status !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_rsp2: valid=%b c=%b st=%b want 1 1110 00", rsp_valid, rsp_c, rsp_status);
        end
        handshake("b2b2");
    endtask

    task automatic test_zero_operands;
        int starts0;
        // Prime alu_c with 0000 so the aborted run leaves 0011 behind.
        send(4'hF, 4'hF, 3'b011);
        repeat (5) @(negedge clk);
        handshake("zero_prime");
        starts0 = alu_starts;
        send(4'h0, 4'h0, 3'b011);
        repeat (5) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_c !== 4'b1111 || rsp_status !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_rsp: valid=%b c=%b st=%b want 1 1111 00", rsp_valid, rsp_c, rsp_status);
        end
        handshake("zero");
        repeat (3) @(negedge clk);
        vectors++;
        if (alu_starts !== starts0 + 1 || alu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_alu_idle: starts=%0d busy=%b want %0d 0", alu_starts, alu_busy, starts0 + 1);
        end
    endtask

    task automatic test_mismatch;
        alu_corrupt = 4'b0100;
        send(4'b1100, 4'b0011, 3'b011);
        repeat (5) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_c !== 4'b1011 || rsp_status !== 2'b10) begin
            miscompares++;
            $display("FAIL mismatch_rsp: valid=%b c=%b st=%b want 1 1011 10", rsp_valid, rsp_c, rsp_status);
        end
        alu_corrupt = 4'b0000;
        handshake("mismatch");
    endtask

    task automatic test_reset_mid_run;
        send(4'h5, 4'h5, 3'b011);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (alu_opcode !== 3'b000 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: op=%b valid=%b ready=%b want 000 0 0", alu_opcode, rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_flush("midrun_flush");
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_no_stale_rsp: valid=%b want 0", rsp_valid);
        end
        send(4'hC, 4'hA, 3'b011);
        repeat (5) @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_c !== 4'b0111 || rsp_status !== 2'b00) begin
            miscompares++;
            $display("FAIL midrun_after: valid=%b c=%b st=%b want 1 0111 00", rsp_valid, rsp_c, rsp_status);
        end
        handshake("midrun_after");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_a       = 4'd0;
        req_b       = 4'd0;
        req_op      = 3'd0;
        rsp_ready   = 1'b0;
        test_reset;
        test_nand_basic;
        test_illegal;
        test_back_to_back;
        test_zero_operands;
        test_mismatch;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
